// File: rtl/miner_nonce_scheduler.sv
// -----------------------------------------------------------------------------
// miner_nonce_scheduler
//
// Hands out nonces from an inclusive range [nonce_start, nonce_end] to an array
// of NUM_CORES miner cores. Each dispatch goes to the lowest-index idle core as
// a one-cycle hash enable pulse, with that core's nonce held until its next
// dispatch. The first reported hit ends the job and latches its nonce. If the
// whole range completes with no hit, the job ends with `exhausted` set.
//
// Optional feature: define MINER_SCHED_WATCHDOG_EN to build a per-core
// 10-bit watchdog. It re-issues a core's nonce after 1023 silent busy cycles
// and sets the sticky `timeout_err`. Without it, `timeout_err` is tied low.
//
// Ports
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   job_start           start pulse, accepted in IDLE/DONE
//   job_abort           synchronous abort back to IDLE (highest priority)
//   nonce_start/_end    inclusive nonce range, sampled on an accepted start
//   core_finished       per-core one-cycle completion pulse
//   core_hit            per-core hit flag, valid with core_finished
//   core_hash_enable    per-core registered one-cycle start pulse
//   core_nonce          per-core nonce, core i in bits [32i+31:32i]
//   busy                high while a job is running
//   found, found_nonce  first hit result
//   exhausted           range completed with no hit
//   timeout_err         sticky watchdog flag
// -----------------------------------------------------------------------------
module miner_nonce_scheduler #(
  parameter int NUM_CORES = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      job_start,
  input  logic                      job_abort,
  input  logic [31:0]               nonce_start,
  input  logic [31:0]               nonce_end,
  input  logic [NUM_CORES-1:0]      core_finished,
  input  logic [NUM_CORES-1:0]      core_hit,
  output logic [NUM_CORES-1:0]      core_hash_enable,
  output logic [32*NUM_CORES-1:0]   core_nonce,
  output logic                      busy,
  output logic                      found,
  output logic [31:0]               found_nonce,
  output logic                      exhausted,
  output logic                      timeout_err
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Lowest set bit of a per-core vector; callers qualify with a reduction-or.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CORES-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_e                       state_q, state_d;
  logic [32:0]                  next_nonce_q, next_nonce_d;
  logic [32:0]                  end_nonce_q, end_nonce_d;
  logic [NUM_CORES-1:0]         core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0]         hash_en_q, hash_en_d;
  logic [NUM_CORES-1:0][31:0]   core_nonce_q, core_nonce_d;
  logic                         busy_q, busy_d;
  logic                         found_q, found_d;
  logic [31:0]                  found_nonce_q, found_nonce_d;
  logic                         exhausted_q, exhausted_d;

  logic [NUM_CORES-1:0]         hit_vec_s;
  logic [NUM_CORES-1:0]         free_vec_s;
  logic [IDX_W-1:0]             hit_idx_s;
  logic [IDX_W-1:0]             free_idx_s;
  logic                         range_left_s;

`ifdef MINER_SCHED_WATCHDOG_EN
  logic                         timeout_q, timeout_d;
  logic [NUM_CORES-1:0][9:0]    wd_cnt_q, wd_cnt_d;
  logic [NUM_CORES-1:0]         wd_vec_s;
  logic [IDX_W-1:0]             wd_idx_s;

  // A busy core that has stayed silent for 1023 cycles is due for a re-issue.
  always_comb begin
    wd_vec_s = {NUM_CORES{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      wd_vec_s[i] = core_busy_q[i] & ~core_finished[i] & (wd_cnt_q[i] == 10'd1023);
    end
  end

  assign wd_idx_s    = lowest_idx(wd_vec_s);
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Hits from cores that were never dispatched are ignored.
  assign hit_vec_s    = core_finished & core_hit & core_busy_q;
  // Uses the registered busy bits, so a core freed this cycle waits one cycle.
  assign free_vec_s   = ~core_busy_q;
  assign hit_idx_s    = lowest_idx(hit_vec_s);
  assign free_idx_s   = lowest_idx(free_vec_s);
  // 33-bit compare so that an end of 0xFFFFFFFF terminates without wrapping.
  assign range_left_s = (next_nonce_q <= end_nonce_q);

  // Next-state logic for the job FSM, dispatch and result registers.
  always_comb begin
    state_d       = state_q;
    next_nonce_d  = next_nonce_q;
    end_nonce_d   = end_nonce_q;
    core_busy_d   = core_busy_q;
    hash_en_d     = {NUM_CORES{1'b0}};
    core_nonce_d  = core_nonce_q;
    busy_d        = busy_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    exhausted_d   = exhausted_q;
`ifdef MINER_SCHED_WATCHDOG_EN
    timeout_d     = timeout_q;
    wd_cnt_d      = wd_cnt_q;
`endif

    if (job_abort) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      found_d     = 1'b0;
      exhausted_d = 1'b0;
      core_busy_d = {NUM_CORES{1'b0}};
      hash_en_d   = {NUM_CORES{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (job_start) begin
            next_nonce_d = {1'b0, nonce_start};
            end_nonce_d  = {1'b0, nonce_end};
            found_d      = 1'b0;
            exhausted_d  = 1'b0;
            core_busy_d  = {NUM_CORES{1'b0}};
            busy_d       = 1'b1;
            state_d      = ST_RUN;
`ifdef MINER_SCHED_WATCHDOG_EN
            timeout_d    = 1'b0;
`endif
          end else begin
            state_d = state_q;
          end
        end

        ST_RUN: begin
          core_busy_d = core_busy_q & ~core_finished;
`ifdef MINER_SCHED_WATCHDOG_EN
          // Counters saturate so a due core stays due until it is re-issued.
          for (int i = 0; i < NUM_CORES; i++) begin
            if (core_busy_q[i] && (wd_cnt_q[i] != 10'd1023)) begin
              wd_cnt_d[i] = wd_cnt_q[i] + 10'd1;
            end else begin
              wd_cnt_d[i] = wd_cnt_q[i];
            end
          end
`endif
          if (|hit_vec_s) begin
            // A hit ends the job; no dispatch is issued in the same cycle.
            found_d       = 1'b1;
            found_nonce_d = core_nonce_q[hit_idx_s];
            busy_d        = 1'b0;
            state_d       = ST_DONE;
          end
`ifdef MINER_SCHED_WATCHDOG_EN
          else if (|wd_vec_s) begin
            // Re-issue the hung core's own nonce and take this cycle's dispatch slot.
            hash_en_d[wd_idx_s] = 1'b1;
            wd_cnt_d[wd_idx_s]  = 10'd0;
            timeout_d           = 1'b1;
          end
`endif
          else if (range_left_s && (|free_vec_s)) begin
            hash_en_d[free_idx_s]    = 1'b1;
            core_nonce_d[free_idx_s] = next_nonce_q[31:0];
            core_busy_d[free_idx_s]  = 1'b1;
            next_nonce_d             = next_nonce_q + 33'd1;
`ifdef MINER_SCHED_WATCHDOG_EN
            wd_cnt_d[free_idx_s]     = 10'd0;
`endif
          end else if (!range_left_s && (core_busy_q == {NUM_CORES{1'b0}})) begin
            exhausted_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_DONE;
          end else begin
            state_d = state_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      next_nonce_q  <= 33'd0;
      end_nonce_q   <= 33'd0;
      core_busy_q   <= {NUM_CORES{1'b0}};
      hash_en_q     <= {NUM_CORES{1'b0}};
      core_nonce_q  <= {(32*NUM_CORES){1'b0}};
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= 32'd0;
      exhausted_q   <= 1'b0;
`ifdef MINER_SCHED_WATCHDOG_EN
      timeout_q     <= 1'b0;
      wd_cnt_q      <= {(10*NUM_CORES){1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      next_nonce_q  <= next_nonce_d;
      end_nonce_q   <= end_nonce_d;
      core_busy_q   <= core_busy_d;
      hash_en_q     <= hash_en_d;
      core_nonce_q  <= core_nonce_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      exhausted_q   <= exhausted_d;
`ifdef MINER_SCHED_WATCHDOG_EN
      timeout_q     <= timeout_d;
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  assign core_hash_enable = hash_en_q;
  assign core_nonce       = core_nonce_q;
  assign busy             = busy_q;
  assign found            = found_q;
  assign found_nonce      = found_nonce_q;
  assign exhausted        = exhausted_q;

endmodule

// File: doc/miner_nonce_scheduler.md
# miner_nonce_scheduler

Distributes a nonce range across `NUM_CORES` miner cores and sequences each core's hash run. Issues one-cycle `hash_enable` pulses with a per-core nonce, collects each core's `finished`/`hit` result, stops on the first hit, and reports exhaustion when the range completes with no hit. Sits between the job/host interface and the array of miner cores; the top level owns each core's header and target registers.

## Interface
- `NUM_CORES`, 4: number of miner cores scheduled, 1..16.
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous active-low reset.
- `job_start` in 1: start pulse; accepted in IDLE or DONE only.
- `job_abort` in 1: synchronous abort; return to IDLE.
- `nonce_start` in 32: first nonce of range; sampled on an accepted `job_start`.
- `nonce_end` in 32: last nonce of range, inclusive; sampled on an accepted `job_start`.
- `core_finished` in NUM_CORES: per-core one-cycle done pulse.
- `core_hit` in NUM_CORES: per-core hash-below-target flag; valid only while that core's `core_finished` is high.
- `core_hash_enable` out NUM_CORES: per-core registered one-cycle start pulse.
- `core_nonce` out 32*NUM_CORES: per-core nonce; core i uses bits [32i+31:32i]. Held stable from the dispatch until the next dispatch to that core.
- `busy` out 1: high in RUN.
- `found` out 1: high in DONE after a hit.
- `found_nonce` out 32: nonce that produced the hit; valid while `found` is high.
- `exhausted` out 1: high in DONE after the range completes with no hit.
- `timeout_err` out 1: sticky watchdog flag. Present only with the macro; otherwise tied to 0.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE and clears every output and register to 0.
- Internal state: 33-bit `next_nonce`, 33-bit `end_nonce` (zero-extended), and a per-core `core_busy` bit.
- IDLE or DONE with `job_start`:
  - load `next_nonce` and `end_nonce`;
  - clear `found`, `exhausted`, `timeout_err` and all `core_busy` bits;
  - go to RUN.
- RUN, dispatch rule:
  - At most one dispatch per cycle.
  - Dispatch happens when `next_nonce <= end_nonce` and at least one core is not busy.
  - The lowest-index non-busy core is chosen.
  - On dispatch: set `core_nonce[i] = next_nonce[31:0]`, pulse `core_hash_enable[i]`, set `core_busy[i]`, increment `next_nonce`.
- The 33-bit compare makes `nonce_end = 0xFFFFFFFF` terminate without wrap-around. `nonce_start > nonce_end` means an empty range.
- Completion:
  - `core_finished[i]` clears `core_busy[i]`. The core becomes eligible for dispatch on the following cycle, not the same cycle.
  - `core_finished[i]` with `core_hit[i]` causes: `found_nonce <= core_nonce[i]`, `found <= 1`, go to DONE.
  - If several cores hit in the same cycle, the lowest index wins.
  - `core_finished` with no matching `core_busy` bit is ignored.
- Exhaustion: in RUN with the range fully dispatched, no busy cores and no hit this cycle, set `exhausted` and go to DONE.
- DONE:
  - Results are held until `job_start` or `job_abort`.
  - No dispatches.
  - Late `core_finished`/`core_hit` inputs are ignored; the first hit is final.
- `job_abort` in any state:
  - go to IDLE on the next edge;
  - clear `busy`, `found`, `exhausted`, all `core_busy` bits and any pending pulse;
  - `job_abort` takes priority over `job_start` and over a same-cycle hit.
- `job_start` while in RUN is ignored.

## Timing
- `job_start` sampled at edge E0: `busy` is high after E0. Core 0 is pulsed at edge E1 with `nonce_start`. Core k (all cores idle) is pulsed at edge E(k+1).
- Hit sampled at edge F: `found` and `found_nonce` are valid after F, and `busy` falls after F (1-cycle latency).
- Core freed at edge F: it is redispatched at F+1 at the earliest.
- Every `core_hash_enable` bit is high for exactly one cycle per dispatch.

## Configuration
- `MINER_SCHED_WATCHDOG_EN` defined:
  - Each busy core has a 10-bit cycle counter, cleared on dispatch.
  - When the counter reaches 1023 without `core_finished`, the core is redispatched with its same `core_nonce` and `timeout_err` is set.
  - `timeout_err` is sticky until the next accepted `job_start` or reset.
  - A redispatch takes priority over a new-nonce dispatch in the same cycle.
- `MINER_SCHED_WATCHDOG_EN` undefined: no counters are built, `timeout_err` is constant 0, and a hung core stalls RUN until `job_abort`.

## Test plan
- NUM_CORES=4, range 0x10..0x17, no hits, each core finishes 340 cycles after its pulse -> nonces 0x10..0x13 dispatched on consecutive cycles, then 0x14..0x17 as cores free; `exhausted`=1, `found`=0.
- Range 0x100..0x1FF, `core_hit` with finish of nonce 0x142 -> `found`=1, `found_nonce`=0x142 one cycle later; no further pulses.
- Cores 1 and 3 hit in the same cycle -> `found_nonce` equals core 1's nonce.
- Range 0xFFFFFFFE..0xFFFFFFFF -> exactly two dispatches, then `exhausted`; no wrap to 0. Range 5..4 -> `exhausted` with zero dispatches.
- `job_abort` mid-RUN with a same-cycle hit -> IDLE, `found`=0; a later `job_start` restarts from the new `nonce_start`.
- With the macro, core 2 never finishes -> redispatched with the same nonce at 1023 cycles, `timeout_err`=1; without the macro, `busy` stays high.
